// File: rtl/core_ctrl_pkg.sv
// Shared control-path constants and FSM state encodings for the core pipeline.
package core_ctrl_pkg;

   // PC after reset
   localparam logic [31:0] CPURstAddress = 32'h0000_0000;

   // Execute-stage hold / jump flag encodings
   localparam logic HoldNone    = 1'b0;
   localparam logic HoldEnable  = 1'b1;
   localparam logic JumpEnable  = 1'b1;
   localparam logic JumpDisable = 1'b0;

   // Bytes per instruction bus word; this is the sequential fetch stride
   localparam logic [31:0] MemByteBus = 32'd4;

   typedef enum logic [1:0] {
      CTRL_BOOT = 2'd0,
      CTRL_RUN  = 2'd1,
      CTRL_HOLD = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/core_ctrl_cnt.sv
// Enable-increment event counter, wraps from all-ones to zero.
module core_ctrl_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   // Count one event per enabled cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/core_ctrl.sv
// Pipeline control: owns the PC, arbitrates jump vs hold from execute and the
// bus, drives stall/flush for IF/ID and ID/EX, and keeps debug event counters.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// CTRL_BOOT | one cycle after reset; no fetch, pipeline stalled
// CTRL_RUN  | fetching; PC advances by 4 or redirects on an accepted jump
// CTRL_HOLD | hold requested; PC frozen, pipeline stalled
module core_ctrl
   import core_ctrl_pkg::*;
#(
   parameter logic [31:0] RST_ADDR  = CPURstAddress,
   parameter logic [31:0] TRAP_ADDR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold_flag_in,
   input  logic        jump_flag_in,
   input  logic [31:0] jump_addr_in,
   input  logic        bus_hold_in,
   input  logic        err_clr_in,
   output logic [31:0] pc_out,
   output logic        inst_valid_out,
   output logic        stall_out,
   output logic        flush_out,
   output logic        misalign_err_out,
   output logic [31:0] jump_count_out,
   output logic [31:0] hold_count_out
);

   ctrl_state_t state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] jump_tgt;
   logic        hold_req;
   logic        jump_acc;
   logic        tgt_misaligned;

   assign hold_req       = (hold_flag_in != HoldNone) | bus_hold_in;
   assign jump_acc       = (jump_flag_in == JumpEnable) & ~hold_req & (state != CTRL_BOOT);
   assign tgt_misaligned = (jump_addr_in[1:0] != 2'b00);
   assign jump_tgt       = tgt_misaligned ? TRAP_ADDR : jump_addr_in;

   // State and PC registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= CTRL_BOOT;
         pc_out <= RST_ADDR;
      end else begin
         state  <= state_nxt;
         pc_out <= pc_nxt;
      end
   end

   // Next state, next PC and same-cycle pipeline controls.
   // The HOLD cycle in which the request drops already fetches the held PC,
   // so it advances (or redirects) exactly like a RUN cycle.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc_out;
      inst_valid_out = 1'b0;
      stall_out      = 1'b0;
      flush_out      = 1'b0;
      unique case (state)
         CTRL_BOOT: begin
            stall_out = 1'b1;
            state_nxt = CTRL_RUN;
         end
         CTRL_RUN, CTRL_HOLD: begin
            stall_out = hold_req;
            if (jump_acc) begin
               pc_nxt    = jump_tgt;
               flush_out = 1'b1;
               state_nxt = CTRL_RUN;
            end else if (hold_req) begin
               state_nxt = CTRL_HOLD;
            end else begin
               pc_nxt         = pc_out + MemByteBus;
               inst_valid_out = 1'b1;
               state_nxt      = CTRL_RUN;
            end
         end
         default: begin
            stall_out = 1'b1;
            state_nxt = CTRL_BOOT;
         end
      endcase
   end

   // Sticky misaligned-target flag; a new error beats a same-cycle clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_err_out <= 1'b0;
      end else if (jump_acc && tgt_misaligned) begin
         misalign_err_out <= 1'b1;
      end else if (err_clr_in) begin
         misalign_err_out <= 1'b0;
      end
   end

   core_ctrl_cnt #(.W(32)) u_jump_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (jump_acc),
      .count (jump_count_out)
   );

   core_ctrl_cnt #(.W(32)) u_hold_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (state == CTRL_HOLD),
      .count (hold_count_out)
   );

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: reset, sequential fetch, jump, hold,
// hold-vs-jump priority, misaligned trap, back-to-back jumps, wrap, async reset.
module tb_core_ctrl;

   localparam logic [31:0] RST_A  = 32'h0000_0000;
   localparam logic [31:0] TRAP_A = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic        hold_flag_in;
   logic        jump_flag_in;
   logic [31:0] jump_addr_in;
   logic        bus_hold_in;
   logic        err_clr_in;
   logic [31:0] pc_out;
   logic        inst_valid_out;
   logic        stall_out;
   logic        flush_out;
   logic        misalign_err_out;
   logic [31:0] jump_count_out;
   logic [31:0] hold_count_out;

   int errors = 0;
   int checks = 0;

   core_ctrl #(.RST_ADDR(RST_A), .TRAP_ADDR(TRAP_A)) dut (
      .clk              (clk),
      .rst              (rst),
      .hold_flag_in     (hold_flag_in),
      .jump_flag_in     (jump_flag_in),
      .jump_addr_in     (jump_addr_in),
      .bus_hold_in      (bus_hold_in),
      .err_clr_in       (err_clr_in),
      .pc_out           (pc_out),
      .inst_valid_out   (inst_valid_out),
      .stall_out        (stall_out),
      .flush_out        (flush_out),
      .misalign_err_out (misalign_err_out),
      .jump_count_out   (jump_count_out),
      .hold_count_out   (hold_count_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reset and return in the first RUN cycle (pc = RST_A)
   task automatic do_reset();
      rst = 1'b1;
      hold_flag_in = 1'b0; jump_flag_in = 1'b0; jump_addr_in = '0;
      bus_hold_in = 1'b0; err_clr_in = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc;
      rst = 1'b1;
      hold_flag_in = 1'b0; jump_flag_in = 1'b0; jump_addr_in = '0;
      bus_hold_in = 1'b0; err_clr_in = 1'b0;
      repeat (2) cyc();
      checks++; if (pc_out !== RST_A) begin errors++; $display("FAIL rst_pc: got %h exp %h", pc_out, RST_A); end
      checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", inst_valid_out); end
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b exp 1", stall_out); end
      checks++; if (flush_out !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b exp 0", flush_out); end
      checks++; if (misalign_err_out !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", misalign_err_out); end
      checks++; if (jump_count_out !== 32'd0 || hold_count_out !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d exp 0/0", jump_count_out, hold_count_out); end
      rst = 1'b0;
      #1;
      checks++; if (stall_out !== 1'b1 || inst_valid_out !== 1'b0) begin errors++; $display("FAIL boot: stall %b valid %b exp 1 0", stall_out, inst_valid_out); end
      exp_pc = RST_A;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++; if (pc_out !== exp_pc || inst_valid_out !== 1'b1 || stall_out !== 1'b0) begin errors++; $display("FAIL seq_pc%0d: got %h valid %b stall %b exp %h 1 0", i, pc_out, inst_valid_out, stall_out, exp_pc); end
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_jump();
      do_reset();
      repeat (2) cyc();
      checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL jmp_pre_pc: got %h exp 8", pc_out); end
      jump_flag_in = 1'b1; jump_addr_in = 32'h40;
      #1;
      checks++; if (flush_out !== 1'b1 || stall_out !== 1'b0 || inst_valid_out !== 1'b0) begin errors++; $display("FAIL jmp_flush: flush %b stall %b valid %b exp 1 0 0", flush_out, stall_out, inst_valid_out); end
      cyc();
      jump_flag_in = 1'b0;
      #1;
      checks++; if (pc_out !== 32'h40 || flush_out !== 1'b0) begin errors++; $display("FAIL jmp_tgt: got %h flush %b exp 40 0", pc_out, flush_out); end
      checks++; if (jump_count_out !== 32'd1) begin errors++; $display("FAIL jmp_cnt: got %0d exp 1", jump_count_out); end
      cyc();
      checks++; if (pc_out !== 32'h44) begin errors++; $display("FAIL jmp_next: got %h exp 44", pc_out); end
   endtask

   task automatic test_hold();
      do_reset();
      repeat (4) cyc();
      bus_hold_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (pc_out !== 32'd16 || stall_out !== 1'b1 || inst_valid_out !== 1'b0) begin errors++; $display("FAIL hold_c%0d: pc %h stall %b valid %b exp 10 1 0", i, pc_out, stall_out, inst_valid_out); end
         cyc();
      end
      bus_hold_in = 1'b0;
      #1;
      checks++; if (pc_out !== 32'd16 || inst_valid_out !== 1'b1 || stall_out !== 1'b0) begin errors++; $display("FAIL hold_refetch: pc %h valid %b stall %b exp 10 1 0", pc_out, inst_valid_out, stall_out); end
      cyc();
      checks++; if (pc_out !== 32'd20) begin errors++; $display("FAIL hold_adv: got %h exp 14", pc_out); end
      checks++; if (hold_count_out !== 32'd3) begin errors++; $display("FAIL hold_cnt: got %0d exp 3", hold_count_out); end
   endtask

   task automatic test_hold_vs_jump();
      do_reset();
      jump_flag_in = 1'b1; jump_addr_in = 32'h80; hold_flag_in = 1'b1;
      #1;
      checks++; if (flush_out !== 1'b0 || stall_out !== 1'b1) begin errors++; $display("FAIL hj_prio: flush %b stall %b exp 0 1", flush_out, stall_out); end
      cyc();
      checks++; if (pc_out !== 32'h0 || jump_count_out !== 32'd0) begin errors++; $display("FAIL hj_held: pc %h jc %0d exp 0 0", pc_out, jump_count_out); end
      hold_flag_in = 1'b0;
      #1;
      checks++; if (flush_out !== 1'b1 || stall_out !== 1'b0) begin errors++; $display("FAIL hj_take: flush %b stall %b exp 1 0", flush_out, stall_out); end
      cyc();
      jump_flag_in = 1'b0;
      #1;
      checks++; if (pc_out !== 32'h80 || jump_count_out !== 32'd1) begin errors++; $display("FAIL hj_tgt: pc %h jc %0d exp 80 1", pc_out, jump_count_out); end
   endtask

   task automatic test_misalign();
      do_reset();
      jump_flag_in = 1'b1; jump_addr_in = 32'h42;
      cyc();
      jump_flag_in = 1'b0;
      #1;
      checks++; if (pc_out !== TRAP_A || misalign_err_out !== 1'b1) begin errors++; $display("FAIL mis_trap: pc %h err %b exp 100 1", pc_out, misalign_err_out); end
      cyc();
      checks++; if (misalign_err_out !== 1'b1 || pc_out !== 32'h104) begin errors++; $display("FAIL mis_sticky: err %b pc %h exp 1 104", misalign_err_out, pc_out); end
      err_clr_in = 1'b1;
      cyc();
      err_clr_in = 1'b0;
      #1;
      checks++; if (misalign_err_out !== 1'b0) begin errors++; $display("FAIL mis_clr: got %b exp 0", misalign_err_out); end
      jump_flag_in = 1'b1; jump_addr_in = 32'h6;
      cyc();
      jump_addr_in = 32'h203; err_clr_in = 1'b1;
      cyc();
      jump_flag_in = 1'b0; err_clr_in = 1'b0;
      #1;
      checks++; if (misalign_err_out !== 1'b1 || pc_out !== TRAP_A || jump_count_out !== 32'd3) begin errors++; $display("FAIL mis_setwins: err %b pc %h jc %0d exp 1 100 3", misalign_err_out, pc_out, jump_count_out); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      jump_flag_in = 1'b1; jump_addr_in = 32'h200;
      cyc();
      jump_addr_in = 32'h300;
      #1;
      checks++; if (pc_out !== 32'h200 || flush_out !== 1'b1) begin errors++; $display("FAIL b2b_first: pc %h flush %b exp 200 1", pc_out, flush_out); end
      cyc();
      jump_flag_in = 1'b0;
      #1;
      checks++; if (pc_out !== 32'h300 || jump_count_out !== 32'd2) begin errors++; $display("FAIL b2b_second: pc %h jc %0d exp 300 2", pc_out, jump_count_out); end
   endtask

   task automatic test_wrap();
      do_reset();
      jump_flag_in = 1'b1; jump_addr_in = 32'hFFFF_FFFC;
      cyc();
      jump_flag_in = 1'b0;
      #1;
      checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre: got %h exp fffffffc", pc_out); end
      cyc();
      checks++; if (pc_out !== 32'h0 || inst_valid_out !== 1'b1) begin errors++; $display("FAIL wrap_pc: got %h valid %b exp 0 1", pc_out, inst_valid_out); end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      jump_flag_in = 1'b1; jump_addr_in = 32'h40;
      cyc();
      jump_flag_in = 1'b0; bus_hold_in = 1'b1;
      repeat (2) cyc();
      checks++; if (hold_count_out !== 32'd1 || pc_out !== 32'h40 || jump_count_out !== 32'd1) begin errors++; $display("FAIL mh_pre: hc %0d pc %h jc %0d exp 1 40 1", hold_count_out, pc_out, jump_count_out); end
      rst = 1'b1;
      #1;
      checks++; if (pc_out !== RST_A || hold_count_out !== 32'd0 || jump_count_out !== 32'd0) begin errors++; $display("FAIL mh_rst: pc %h hc %0d jc %0d exp 0 0 0", pc_out, hold_count_out, jump_count_out); end
      checks++; if (stall_out !== 1'b1 || inst_valid_out !== 1'b0) begin errors++; $display("FAIL mh_boot: stall %b valid %b exp 1 0", stall_out, inst_valid_out); end
      bus_hold_in = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_jump();
      test_hold();
      test_hold_vs_jump();
      test_misalign();
      test_back_to_back();
      test_wrap();
      test_reset_mid_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Pipeline control block. It receives the hold/jump outputs of the execute stage and owns the program counter. It produces the fetch address plus the stall and flush controls for the IF/ID and ID/EX pipeline registers. It sits between `core_ex` (upstream) and the fetch unit and pipeline registers (downstream), and also keeps jump/hold event counters for debug.

## Interface
Parameters:
- `RST_ADDR`, default 32'h0000_0000: PC value after reset (matches `CPURstAddress`).
- `TRAP_ADDR`, default 32'h0000_0100: PC loaded on a misaligned jump target.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `hold_flag_in` in 1: hold request from execute stage (`HoldNone` = 0).
- `jump_flag_in` in 1: jump request from execute stage (`JumpEnable` = 1).
- `jump_addr_in` in 32: jump target from execute stage.
- `bus_hold_in` in 1: hold request from memory bus arbiter.
- `err_clr_in` in 1: clears `misalign_err_out`.
- `pc_out` out 32: current fetch address (registered).
- `inst_valid_out` out 1: fetch at `pc_out` is valid this cycle.
- `stall_out` out 1: freeze IF/ID and ID/EX registers this cycle.
- `flush_out` out 1: load NOP into IF/ID and ID/EX at next edge.
- `misalign_err_out` out 1: sticky, a jump target had `addr[1:0] != 0`.
- `jump_count_out` out 32: accepted jumps since reset, wraps.
- `hold_count_out` out 32: cycles spent in HOLD since reset, wraps.

## Operation
- States: BOOT, RUN, HOLD. Reset enters BOOT.
- hold_req = `hold_flag_in | bus_hold_in`.
- jump_acc = `jump_flag_in & ~hold_req & (state != BOOT)`.
- BOOT: lasts exactly one cycle, then goes to RUN unconditionally. PC is unchanged, `inst_valid_out`=0, `stall_out`=1, jumps and holds are ignored.
- RUN:
  - If jump_acc: PC <= target, `flush_out`=1, `jump_count_out` += 1, stay in RUN.
  - Else if hold_req: PC unchanged, go to HOLD.
  - Else: PC <= PC + 4.
- HOLD: PC unchanged and `stall_out`=1. `hold_count_out` += 1 each cycle while in HOLD. Go to RUN when hold_req = 0. The first RUN cycle re-fetches the held PC, and PC advances at the end of that cycle.
- Target selection: if `jump_addr_in[1:0] == 0`, target = `jump_addr_in`. Otherwise target = `TRAP_ADDR` and `misalign_err_out` <= 1.
- Jump has priority over sequential increment. Hold has priority over jump: a jump presented while hold_req = 1 is not taken. Execute re-presents it after the hold clears.
- `misalign_err_out` is set on a misaligned accepted jump and cleared by `err_clr_in`. If both happen in the same cycle, set wins.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. Counters wrap from all-ones to 0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A pending jump or hold is discarded.

## Timing
- Reset values: `pc_out`=`RST_ADDR`, `inst_valid_out`=0, `stall_out`=1 (BOOT), `flush_out`=0, `misalign_err_out`=0, both counters 0.
- First valid fetch is the second cycle after `rst` deasserts. `pc_out`=`RST_ADDR` in that cycle.
- `pc_out`, state, counters and error flag are registered.
- `flush_out` and `stall_out` are combinational from the current inputs and state, valid in the same cycle. Redirect latency is 1: jump seen in cycle N, `pc_out` = target in cycle N+1, with exactly one flush cycle (N).
- `inst_valid_out` = (state != BOOT) & ~hold_req & ~jump_acc.
- `stall_out` = (state == BOOT) | hold_req. `stall_out` and `flush_out` are never 1 in the same cycle.
- Back-to-back jumps in consecutive cycles are each accepted and counted.

## Structure
- Shared defines header holds `CPURstAddress`, `HoldNone`/`HoldEnable`, `JumpEnable`/`JumpDisable`, `MemByteBus`, and the new state encodings `CTRL_BOOT`/`CTRL_RUN`/`CTRL_HOLD` (2-bit).
- Natural sub-module: `core_ctrl_cnt`, a 32-bit enable-increment wrapping counter with async reset, instantiated twice (jump and hold counters).
- The PC register and FSM stay in `core_ctrl`.

## Test plan
- Reset release, no requests -> cycle 1 BOOT (`stall_out`=1, valid=0). Then `pc_out` = 0, 4, 8, 12 on consecutive cycles with valid=1.
- Jump to 32'h40 at PC 8 -> `flush_out`=1 that cycle; next `pc_out`=32'h40, then 32'h44; `jump_count_out`=1.
- `bus_hold_in` high 3 cycles at PC 16 -> `pc_out` stays 16 and `stall_out`=1 for 3 cycles; `hold_count_out`=3; then PC 16 (valid), then 20.
- `jump_flag_in` and `hold_flag_in` both high -> no flush, PC held, `jump_count_out` unchanged. Hold drops with jump still asserted -> jump taken next cycle.
- Jump to 32'h42 -> `pc_out`=`TRAP_ADDR` (32'h100), `misalign_err_out`=1 until `err_clr_in`. `err_clr_in` on the same cycle as a new misaligned jump -> flag stays 1.
- PC at 32'hFFFF_FFFC in RUN -> next `pc_out`=0. Assert `rst` mid-HOLD -> `pc_out`=`RST_ADDR` and counters 0 immediately.
